// File: rtl/shape_cfg_pkg.sv
// Shared types, field layout, reset constants and SFR legality rules for the
// shape control SFR master.
package shape_cfg_pkg;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        REJECTED = 2'd1,
        MISMATCH = 2'd2
    } status_t;

    localparam int unsigned SHAPE_LSB = 16;
    localparam int unsigned SHAPE_W   = 3;
    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned OP_W      = 7;

    // All-ones in a field tells the SFR to keep its current value.
    localparam logic [2:0] KEEP_SHAPE     = 3'b111;
    localparam logic [6:0] KEEP_OPERATION = 7'h7F;

    localparam logic [2:0] SFR_RST_SHAPE     = 3'b001;
    localparam logic [6:0] SFR_RST_OPERATION = 7'h00;

    function automatic logic is_legal_shape(input logic [2:0] shape);
        return (shape == 3'b001) || (shape == 3'b010) || (shape == 3'b100);
    endfunction

    function automatic logic is_legal_operation(input logic [6:0] operation);
        logic legal;
        case (operation[6:4])
            3'b000:  legal = (operation[3:0] == 4'd0) || (operation[3:0] == 4'd1);
            3'b010:  legal = (operation[3:0] == 4'd0);
            3'b100:  legal = (operation[3:0] == 4'd0) || (operation[3:0] == 4'd1);
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_legal_combination(input logic [2:0] shape,
                                                  input logic [6:0] operation);
        return (operation[6:4] == 3'b000) || (operation[6:4] == shape);
    endfunction

    function automatic logic [2:0] resolve_shape(input logic       keep,
                                                 input logic [2:0] shape,
                                                 input logic [2:0] shadow);
        return (keep || shape == KEEP_SHAPE) ? shadow : shape;
    endfunction

    function automatic logic [6:0] resolve_operation(input logic       keep,
                                                     input logic [6:0] operation,
                                                     input logic [6:0] shadow);
        return (keep || operation == KEEP_OPERATION) ? shadow : operation;
    endfunction

    function automatic logic [31:0] encode_write(input logic [2:0] shape,
                                                 input logic [6:0] operation);
        logic [31:0] data;
        data = '0;
        data[SHAPE_LSB +: SHAPE_W] = shape;
        data[OP_LSB +: OP_W]       = operation;
        return data;
    endfunction

endpackage

// File: rtl/shape_cfg_predictor.sv
// Combinational model of how the SFR will treat a request, given the
// master's shadow copy of the SFR contents.
module shape_cfg_predictor
    import shape_cfg_pkg::*;
(
    input  logic [2:0] req_shape,
    input  logic [6:0] req_operation,
    input  logic       keep_shape,
    input  logic       keep_operation,
    input  logic [2:0] shadow_shape,
    input  logic [6:0] shadow_operation,
    output logic [2:0] resolved_shape,
    output logic [6:0] resolved_operation,
    output logic       accept,
    output logic [2:0] expected_shape,
    output logic [6:0] expected_operation
);

    always_comb begin
        resolved_shape     = resolve_shape(keep_shape, req_shape, shadow_shape);
        resolved_operation = resolve_operation(keep_operation, req_operation, shadow_operation);
        accept             = is_legal_shape(resolved_shape)
                          && is_legal_operation(resolved_operation)
                          && is_legal_combination(resolved_shape, resolved_operation);
        expected_shape     = accept ? resolved_shape     : shadow_shape;
        expected_operation = accept ? resolved_operation : shadow_operation;
    end

endmodule

// File: rtl/shape_cfg_master.sv
// Bus initiator for the shape control SFR: write request, read back, report status.
// Optional predictor and sticky error enabled by SHAPE_CFG_MASTER_PREDICT_EN.
module shape_cfg_master
    import shape_cfg_pkg::*;
#(
    parameter int unsigned READ_DELAY    = 0,
    parameter logic [2:0]  RST_SHAPE     = SFR_RST_SHAPE,
    parameter logic [6:0]  RST_OPERATION = SFR_RST_OPERATION
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_shape,
    input  logic [6:0]  req_operation,
    input  logic        req_keep_shape,
    input  logic        req_keep_operation,
    output logic        write,
    output logic [31:0] write_data,
    output logic        read,
    input  logic [31:0] read_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [2:0]  rsp_shape,
    output logic [6:0]  rsp_operation,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, RESP} state_t;

    localparam logic [3:0] DELAY_LAST = (READ_DELAY == 0) ? 4'd0 : 4'(READ_DELAY - 1);

    state_t     state, next_state;
    logic [3:0] cnt, cnt_next;
    logic [2:0] lat_shape, shadow_shape, rd_shape, res_shape;
    logic [6:0] lat_operation, shadow_operation, rd_operation, res_operation;
    logic       lat_keep_shape, lat_keep_operation;
    status_t    status_next;
    logic       unused_read_bits;

    assign rd_shape         = read_data[SHAPE_LSB +: SHAPE_W];
    assign rd_operation     = read_data[OP_LSB +: OP_W];
    assign unused_read_bits = ^{read_data[31:19], read_data[15:7]};

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE:  if (req_valid) next_state = WRITE;
            WRITE: begin
                cnt_next   = '0;
                next_state = (READ_DELAY > 0) ? WAIT : READ;
            end
            WAIT: begin
                if (cnt == DELAY_LAST) next_state = READ;
                else                   cnt_next   = cnt + 4'd1;
            end
            READ:  next_state = RESP;
            RESP:  if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

`ifdef SHAPE_CFG_MASTER_PREDICT_EN
    logic [2:0] exp_shape;
    logic [6:0] exp_operation;
    logic       accept;
    logic       unused_resolved;
    logic       error_q;

    shape_cfg_predictor u_predictor (
        .req_shape          (lat_shape),
        .req_operation      (lat_operation),
        .keep_shape         (lat_keep_shape),
        .keep_operation     (lat_keep_operation),
        .shadow_shape       (shadow_shape),
        .shadow_operation   (shadow_operation),
        .resolved_shape     (res_shape),
        .resolved_operation (res_operation),
        .accept             (accept),
        .expected_shape     (exp_shape),
        .expected_operation (exp_operation)
    );

    assign unused_resolved = ^{res_shape, res_operation};

    always_comb begin
        status_next = OK;
        if ({rd_shape, rd_operation} != {exp_shape, exp_operation}) status_next = MISMATCH;
        else if (!accept)                                          status_next = REJECTED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     error_q <= 1'b0;
        else if (state == READ && status_next == MISMATCH) error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign res_shape     = resolve_shape(lat_keep_shape, lat_shape, shadow_shape);
    assign res_operation = resolve_operation(lat_keep_operation, lat_operation, shadow_operation);

    always_comb begin
        status_next = ({rd_shape, rd_operation} == {res_shape, res_operation}) ? OK : REJECTED;
    end

    assign error = 1'b0;
`endif

    // Strobes and handshake flags are registered from next_state so that
    // reset drops them directly and they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            req_ready          <= 1'b1;
            write              <= 1'b0;
            read               <= 1'b0;
            rsp_valid          <= 1'b0;
            write_data         <= '0;
            rsp_status         <= OK;
            rsp_shape          <= RST_SHAPE;
            rsp_operation      <= RST_OPERATION;
            shadow_shape       <= RST_SHAPE;
            shadow_operation   <= RST_OPERATION;
            lat_shape          <= '0;
            lat_operation      <= '0;
            lat_keep_shape     <= 1'b0;
            lat_keep_operation <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            req_ready <= (next_state == IDLE);
            write     <= (next_state == WRITE);
            read      <= (next_state == READ);
            rsp_valid <= (next_state == RESP);
            if (state == IDLE && req_valid) begin
                lat_shape          <= req_shape;
                lat_operation      <= req_operation;
                lat_keep_shape     <= req_keep_shape;
                lat_keep_operation <= req_keep_operation;
                write_data         <= encode_write(req_keep_shape ? KEEP_SHAPE : req_shape,
                                                   req_keep_operation ? KEEP_OPERATION : req_operation);
            end
            if (state == READ) begin
                rsp_shape        <= rd_shape;
                rsp_operation    <= rd_operation;
                shadow_shape     <= rd_shape;
                shadow_operation <= rd_operation;
                rsp_status       <= status_next;
            end
        end
    end

endmodule

// File: tb/tb_shape_cfg_master.sv
// Randomized bench for shape_cfg_master: one instance with no read delay and
// one with READ_DELAY=2, each served by a behavioural SFR model.
module tb_shape_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, write, read, rsp_valid, error;
    logic [2:0]  req_shape;
    logic [6:0]  req_operation;
    logic        req_keep_shape, req_keep_operation, rsp_ready;
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic [1:0]  rsp_status [2];
    logic [2:0]  rsp_shape  [2];
    logic [6:0]  rsp_operation [2];
    logic [1:0]  force_zero;

    logic [9:0]  sfr [2];         // {shape, operation} held by each SFR model
    logic [9:0]  shadow_ref [2];  // what the master believes the SFR holds
    logic [1:0]  err_ref;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shape_cfg_master #(.READ_DELAY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_shape(req_shape), .req_operation(req_operation),
        .req_keep_shape(req_keep_shape), .req_keep_operation(req_keep_operation),
        .write(write[0]), .write_data(write_data[0]),
        .read(read[0]), .read_data(read_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status[0]), .rsp_shape(rsp_shape[0]),
        .rsp_operation(rsp_operation[0]), .error(error[0])
    );

    shape_cfg_master #(.READ_DELAY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_shape(req_shape), .req_operation(req_operation),
        .req_keep_shape(req_keep_shape), .req_keep_operation(req_keep_operation),
        .write(write[1]), .write_data(write_data[1]),
        .read(read[1]), .read_data(read_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status[1]), .rsp_shape(rsp_shape[1]),
        .rsp_operation(rsp_operation[1]), .error(error[1])
    );

    function automatic logic legal(input logic [9:0] v);
        logic [2:0] s;
        logic [6:0] o;
        s = v[9:7];
        o = v[6:0];
        return ($countones(s) == 1) && (o inside {7'h00, 7'h01, 7'h20, 7'h40, 7'h41})
            && (o[6:4] == 3'b000 || o[6:4] == s);
    endfunction

    function automatic logic [9:0] sfr_next(input logic [9:0] cur, input logic [31:0] wd);
        logic [9:0] r;
        r[9:7] = (wd[18:16] == 3'b111) ? cur[9:7] : wd[18:16];
        r[6:0] = (wd[6:0] == 7'h7F) ? cur[6:0] : wd[6:0];
        return legal(r) ? r : cur;
    endfunction

    assign read_data[0] = force_zero[0] ? 32'h0 : {13'h0, sfr[0][9:7], 9'h0, sfr[0][6:0]};
    assign read_data[1] = force_zero[1] ? 32'h0 : {13'h0, sfr[1][9:7], 9'h0, sfr[1][6:0]};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sfr[0] <= {3'b001, 7'h00};
            sfr[1] <= {3'b001, 7'h00};
        end else begin
            if (write[0]) sfr[0] <= sfr_next(sfr[0], write_data[0]);
            if (write[1]) sfr[1] <= sfr_next(sfr[1], write_data[1]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_refs();
        shadow_ref[0] = {3'b001, 7'h00};
        shadow_ref[1] = {3'b001, 7'h00};
        err_ref       = 2'b00;
    endtask

    task automatic do_txn(input int u, input logic [2:0] shp, input logic [6:0] op,
                          input logic ks, input logic ko, input logic fz, input int hold);
        logic [31:0] exp_wd;
        logic [9:0]  res, rb;
        logic [1:0]  exp_st;
        logic        acc;
        int          dly;
        dly    = (u == 0) ? 0 : 2;
        exp_wd = {13'h0, (ks ? 3'b111 : shp), 9'h0, (ko ? 7'h7F : op)};
        rb     = fz ? 10'h0 : sfr_next(sfr[u], exp_wd);
        res    = {((ks || shp == 3'b111) ? shadow_ref[u][9:7] : shp),
                  ((ko || op == 7'h7F) ? shadow_ref[u][6:0] : op)};
        acc    = legal(res);
`ifdef SHAPE_CFG_MASTER_PREDICT_EN
        if (rb != (acc ? res : shadow_ref[u])) begin
            exp_st     = 2'd2;
            err_ref[u] = 1'b1;
        end else begin
            exp_st = acc ? 2'd0 : 2'd1;
        end
`else
        exp_st = (rb == res) ? 2'd0 : 2'd1;
`endif
        shadow_ref[u] = rb;

        @(negedge clk);
        check("idle_ready", req_ready[u], 1);
        force_zero[u]      = fz;
        req_shape          = shp;
        req_operation      = op;
        req_keep_shape     = ks;
        req_keep_operation = ko;
        req_valid[u]       = 1'b1;
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        check("write_cycle", {write[u], read[u], req_ready[u]}, 3'b100);
        check("write_data", write_data[u], exp_wd);
        for (int d = 0; d < dly; d++) begin
            @(posedge clk); #1;
            check("wait_quiet", {write[u], read[u], rsp_valid[u]}, 3'b000);
        end
        @(posedge clk); #1;
        check("read_cycle", {write[u], read[u], rsp_valid[u]}, 3'b010);
        @(posedge clk); #1;
        check("rsp_valid", {rsp_valid[u], req_ready[u], read[u]}, 3'b100);
        check("rsp_status", rsp_status[u], exp_st);
        check("rsp_fields", {rsp_shape[u], rsp_operation[u]}, rb);
        check("error", error[u], err_ref[u]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("rsp_hold", {rsp_valid[u], req_ready[u], write[u], read[u], rsp_status[u],
                               rsp_shape[u], rsp_operation[u]}, {4'b1000, exp_st, rb});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready     = 1'b0;
        force_zero[u] = 1'b0;
        check("rsp_done", {rsp_valid[u], req_ready[u]}, 2'b01);
    endtask

    initial begin
        logic [2:0] shp;
        logic [6:0] op;
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        force_zero = '0;
        req_shape = '0;
        req_operation = '0;
        req_keep_shape = 1'b0;
        req_keep_operation = 1'b0;
        reset_refs();
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 2'b11);
        check("rst_strobes", {write, read, rsp_valid, error}, 8'h00);
        check("rst_write_data", write_data[0], 32'h0);
        check("rst_rsp", {rsp_status[0], rsp_shape[0], rsp_operation[0]}, {2'd0, 3'b001, 7'h00});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_txn(0, 3'b010, 7'h20, 1'b0, 1'b0, 1'b0, 0);
        do_txn(0, 3'b001, 7'h20, 1'b0, 1'b0, 1'b0, 1);
        do_txn(0, 3'b100, 7'h00, 1'b0, 1'b0, 1'b0, 0);
        do_txn(0, 3'b011, 7'h41, 1'b1, 1'b0, 1'b0, 0);
        do_txn(0, 3'b010, 7'h20, 1'b0, 1'b0, 1'b1, 5);
        do_txn(0, 3'b100, 7'h40, 1'b0, 1'b0, 1'b0, 0);
        do_txn(0, 3'b001, 7'h01, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            shp = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: op = 7'h00;
                1: op = 7'h01;
                2: op = 7'h20;
                3: op = 7'h40;
                4: op = 7'h41;
                5: op = 7'h7F;
                default: op = 7'($urandom);
            endcase
            do_txn(0, shp, op, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)));
        end

        do_txn(1, 3'b010, 7'h20, 1'b0, 1'b0, 1'b0, 2);
        do_txn(1, 3'b100, 7'h41, 1'b0, 1'b0, 1'b0, 0);
        do_txn(1, 3'b001, 7'h7F, 1'b0, 1'b1, 1'b0, 0);

        // Abort the slow instance while it is waiting to read.
        @(negedge clk);
        req_shape = 3'b100;
        req_operation = 7'h01;
        req_keep_shape = 1'b0;
        req_keep_operation = 1'b0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("abort_write", write[1], 1);
        @(posedge clk); #1;
        check("abort_in_wait", {write[1], read[1], rsp_valid[1]}, 3'b000);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", {write[1], read[1], rsp_valid[1], req_ready[1]}, 4'b0001);
        check("abort_write_data", write_data[1], 32'h0);
        check("abort_rsp", {rsp_status[1], rsp_shape[1], rsp_operation[1]}, {2'd0, 3'b001, 7'h00});
        check("abort_error", error, 2'b00);
        reset_refs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {rsp_valid[1], read[1], write[1], req_ready[1]}, 4'b0001);
        end
        do_txn(1, 3'b010, 7'h20, 1'b0, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
